// File: rtl/frame_pkg.sv
// frame_pkg: command, error, FSM state and operand-stack encodings shared by frame_sequencer.
// Stack op and stack error codes mirror the SuperStack encoding.
package frame_pkg;
    typedef enum logic [2:0] {
        CMD_CALL, CMD_RETURN, CMD_LOCAL_GET, CMD_LOCAL_SET, CMD_LOCAL_TEE
    } cmd_t;
    typedef enum logic [2:0] {
        ERR_NONE, ERR_FRAME_OVF, ERR_NO_FRAME, ERR_ARGS,
        ERR_STACK_OVF, ERR_UNDERFLOW, ERR_BAD_LOCAL, ERR_STACK
    } err_t;
    typedef enum logic [2:0] {IDLE, EXEC, CHECK, PUSH, CHECK2} state_t;
    typedef enum logic [2:0] {
        STK_NONE, STK_PUSH, STK_POP, STK_INDEX_RESET, STK_INDEX_RESET_AND_PUSH,
        STK_UNDERFLOW_GET, STK_UNDERFLOW_SET
    } stk_op_t;
    typedef enum logic [1:0] {
        SERR_NONE, SERR_UNDERFLOW, SERR_OVERFLOW, SERR_BAD_OFFSET
    } stk_err_t;
endpackage

// File: rtl/frame_record_lifo.sv
// frame_record_lifo: LIFO of saved {base, limit} frame records.
// Only the level pointer is reset; record storage keeps its contents.
module frame_record_lifo #(
    parameter int DW     = 8,
    parameter int FRAMES = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [DW-1:0]            i_din,
    output logic [DW-1:0]            o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(FRAMES):0]  o_level
);
    localparam int AW = $clog2(FRAMES);
    logic [DW-1:0] r_mem [FRAMES];
    logic [AW:0]   r_level;
    logic [AW:0]   w_dec;
    assign w_dec   = r_level - 1'b1;
    assign o_dout  = r_mem[w_dec[AW-1:0]];
    assign o_full  = r_level[AW];
    assign o_empty = r_level == '0;
    assign o_level = r_level;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_level <= '0;
        else if (i_push && !o_full)
            r_level <= r_level + 1'b1;
        else if (i_pop && !o_empty)
            r_level <= w_dec;
    end
    always_ff @(posedge clk) begin
        if (i_push && !o_full)
            r_mem[r_level[AW-1:0]] <= i_din;
    end
endmodule

// File: rtl/frame_sequencer.sv
// frame_sequencer: call-frame controller turning CALL/RETURN/LOCAL_* commands into operand-stack ops.
// Define FRAME_SEQUENCER_HWM_EN to add the hwm and frame_hwm high-water-mark outputs.
module frame_sequencer
    import frame_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 3,
    parameter int FRAMES = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [2:0]               cmd_op,
    input  logic [DEPTH:0]           cmd_a,
    input  logic [DEPTH:0]           cmd_b,
    output logic                     done,
    output logic [2:0]               err,
    output logic [$clog2(FRAMES):0]  frame_level,
    output logic [2:0]               stk_op,
    output logic [WIDTH-1:0]         stk_data,
    output logic [DEPTH:0]           stk_offset,
    output logic [DEPTH:0]           stk_underflow_limit,
    output logic [DEPTH:0]           stk_upper_limit,
    output logic [DEPTH:0]           stk_lower_limit,
    output logic                     stk_drop_tos,
    input  logic [DEPTH:0]           stk_index,
    input  logic [WIDTH-1:0]         stk_out,
    input  logic [WIDTH-1:0]         stk_getter,
    input  logic [1:0]               stk_error
`ifdef FRAME_SEQUENCER_HWM_EN
   ,output logic [DEPTH:0]           hwm,
    output logic [$clog2(FRAMES):0]  frame_hwm
`endif
);
    localparam logic [DEPTH+1:0] MAX_STACK = {1'b0, 1'b1, {DEPTH{1'b0}}};
    state_t             r_state, w_state;
    cmd_t               r_op;
    logic [DEPTH:0]     r_a, r_b, r_base, r_limit, w_base, w_limit;
    logic               r_done, w_done, w_push, w_pop, w_full, w_empty, w_nres;
    logic [2:0]         r_err, w_err, w_pre, w_call_err, w_ret_err, w_chk_err;
    logic [2*DEPTH+1:0] w_top;
    logic [DEPTH+1:0]   w_args_x, w_end_x;
    stk_err_t           w_serr;
    frame_record_lifo #(.DW(2*(DEPTH+1)), .FRAMES(FRAMES)) u_lifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   ({r_base, r_limit}),
        .o_dout  (w_top),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (frame_level)
    );
    // Widened by one bit so nargs+limit and index+nlocals cannot wrap before comparing.
    assign w_args_x   = {1'b0, r_a} + {1'b0, r_limit};
    assign w_end_x    = {1'b0, stk_index} + {1'b0, r_b};
    assign w_nres     = r_a != '0;
    assign w_serr     = stk_err_t'(stk_error);
    assign w_call_err = w_full ? ERR_FRAME_OVF : w_args_x > {1'b0, stk_index} ? ERR_ARGS :
                        w_end_x > MAX_STACK ? ERR_STACK_OVF : ERR_NONE;
    assign w_ret_err  = w_empty ? ERR_NO_FRAME : (w_nres && stk_index == r_limit) ? ERR_UNDERFLOW : ERR_NONE;
    assign w_pre      = r_op == CMD_CALL ? w_call_err : r_op == CMD_RETURN ? w_ret_err : ERR_NONE;
    assign w_chk_err  = r_op == CMD_RETURN ? (w_serr != SERR_NONE ? ERR_STACK : ERR_NONE) :
                        r_op == CMD_CALL ? ERR_NONE :
                        w_serr == SERR_BAD_OFFSET ? ERR_BAD_LOCAL :
                        w_serr == SERR_UNDERFLOW ? ERR_UNDERFLOW : ERR_NONE;
    assign cmd_ready           = r_state == IDLE;
    assign done                = r_done;
    assign err                 = r_err;
    assign stk_lower_limit     = r_base;
    assign stk_upper_limit     = r_limit;
    assign stk_underflow_limit = r_limit;
    always_comb begin
        w_state      = r_state;
        w_done       = 1'b0;
        w_err        = ERR_NONE;
        w_base       = r_base;
        w_limit      = r_limit;
        w_push       = 1'b0;
        w_pop        = 1'b0;
        stk_op       = STK_NONE;
        stk_data     = stk_out;
        stk_offset   = r_a;
        stk_drop_tos = 1'b0;
        case (r_state)
            IDLE: w_state = cmd_valid ? EXEC : IDLE;
            EXEC: begin
                if (w_pre != ERR_NONE) begin
                    w_state = IDLE;
                    w_done  = 1'b1;
                    w_err   = w_pre;
                end else begin
                    w_state = CHECK;
                    case (r_op)
                        CMD_CALL: begin
                            w_push     = 1'b1;
                            w_base     = stk_index - r_a;
                            w_limit    = w_end_x[DEPTH:0];
                            stk_op     = STK_INDEX_RESET;
                            stk_offset = w_end_x[DEPTH:0];
                        end
                        CMD_RETURN: begin
                            w_pop      = 1'b1;
                            w_base     = w_top[2*DEPTH+1:DEPTH+1];
                            w_limit    = w_top[DEPTH:0];
                            stk_op     = w_nres ? STK_INDEX_RESET_AND_PUSH : STK_INDEX_RESET;
                            stk_offset = r_base;
                        end
                        CMD_LOCAL_GET: stk_op = STK_UNDERFLOW_GET;
                        default: begin
                            stk_op       = STK_UNDERFLOW_SET;
                            stk_drop_tos = r_op == CMD_LOCAL_SET;
                        end
                    endcase
                end
            end
            CHECK: begin
                w_state = (r_op == CMD_LOCAL_GET && w_serr != SERR_BAD_OFFSET) ? PUSH : IDLE;
                w_done  = w_state == IDLE;
                w_err   = w_state == IDLE ? w_chk_err : ERR_NONE;
            end
            PUSH: begin
                w_state  = CHECK2;
                stk_op   = STK_PUSH;
                stk_data = stk_getter;
            end
            CHECK2: begin
                w_state = IDLE;
                w_done  = 1'b1;
                w_err   = w_serr == SERR_OVERFLOW ? ERR_STACK_OVF : ERR_NONE;
            end
            default: w_state = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_op    <= CMD_CALL;
            r_a     <= '0;
            r_b     <= '0;
            r_base  <= '0;
            r_limit <= '0;
            r_done  <= 1'b0;
            r_err   <= ERR_NONE;
        end else begin
            r_state <= w_state;
            r_base  <= w_base;
            r_limit <= w_limit;
            r_done  <= w_done;
            r_err   <= w_err;
            if (r_state == IDLE && cmd_valid) begin
                r_op <= cmd_t'(cmd_op);
                r_a  <= cmd_a;
                r_b  <= cmd_b;
            end
        end
    end
`ifdef FRAME_SEQUENCER_HWM_EN
    logic [DEPTH:0]              r_hwm;
    logic [$clog2(FRAMES):0]     r_frame_hwm;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hwm       <= '0;
            r_frame_hwm <= '0;
        end else begin
            r_hwm       <= stk_index > r_hwm ? stk_index : r_hwm;
            r_frame_hwm <= frame_level > r_frame_hwm ? frame_level : r_frame_hwm;
        end
    end
    assign hwm       = r_hwm;
    assign frame_hwm = r_frame_hwm;
`endif
endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer: directed bench for frame_sequencer driving a small behavioural operand stack.
module tb_frame_sequencer;
    import frame_pkg::*;
    logic       clk = 1'b0, reset = 1'b1;
    logic       cmd_valid = 1'b0, cmd_ready, done, stk_drop_tos;
    logic [2:0] cmd_op = '0, err, stk_op;
    logic [3:0] cmd_a = '0, cmd_b = '0, frame_level, stk_offset;
    logic [3:0] stk_underflow_limit, stk_upper_limit, stk_lower_limit, stk_index;
    logic [7:0] stk_data, stk_out, stk_getter;
    logic [1:0] stk_error;
    logic [2:0] tb_op = '0, m_op;
    logic [7:0] tb_data = '0, m_data;
    logic [7:0] s_mem [16];
    logic [3:0] s_idx = '0;
    logic [1:0] s_err = '0;
    logic [7:0] s_get = '0;
    int         slot;
    int         n_cmp = 0, n_bad = 0;
    int         lat;
    logic [2:0] e, op0;
    logic [3:0] off0;
    logic       drop0;
    always #5 clk = ~clk;
    frame_sequencer #(.WIDTH(8), .DEPTH(3), .FRAMES(8)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .done(done), .err(err),
        .frame_level(frame_level), .stk_op(stk_op), .stk_data(stk_data), .stk_offset(stk_offset),
        .stk_underflow_limit(stk_underflow_limit), .stk_upper_limit(stk_upper_limit),
        .stk_lower_limit(stk_lower_limit), .stk_drop_tos(stk_drop_tos), .stk_index(stk_index),
        .stk_out(stk_out), .stk_getter(stk_getter), .stk_error(stk_error)
    );
    assign stk_index  = s_idx;
    assign stk_out    = s_idx == 4'd0 ? 8'd0 : s_mem[s_idx - 4'd1];
    assign stk_getter = s_get;
    assign stk_error  = s_err;
    assign m_op       = tb_op != 3'd0 ? tb_op : stk_op;
    assign m_data     = tb_op != 3'd0 ? tb_data : stk_data;
    assign slot       = int'(stk_lower_limit) + int'(stk_offset);
    // Eight-entry operand stack; error code is registered like the real one.
    always @(posedge clk) begin
        s_err <= SERR_NONE;
        case (m_op)
            STK_PUSH:
                if (s_idx >= 4'd8) s_err <= SERR_OVERFLOW;
                else begin
                    s_mem[s_idx] <= m_data;
                    s_idx <= s_idx + 4'd1;
                end
            STK_INDEX_RESET: s_idx <= stk_offset;
            STK_INDEX_RESET_AND_PUSH: begin
                s_mem[stk_offset] <= m_data;
                s_idx <= stk_offset + 4'd1;
            end
            STK_UNDERFLOW_GET:
                if (slot >= int'(stk_upper_limit)) s_err <= SERR_BAD_OFFSET;
                else s_get <= s_mem[slot];
            STK_UNDERFLOW_SET:
                if (slot >= int'(stk_upper_limit)) s_err <= SERR_BAD_OFFSET;
                else if (s_idx <= stk_underflow_limit) s_err <= SERR_UNDERFLOW;
                else begin
                    s_mem[slot] <= stk_out;
                    if (stk_drop_tos) s_idx <= s_idx - 4'd1;
                end
            default: ;
        endcase
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic stk_push(input logic [7:0] d);
        @(negedge clk);
        tb_op   = STK_PUSH;
        tb_data = d;
        @(negedge clk);
        tb_op   = STK_NONE;
    endtask
    // Latency counts the accept cycle as cycle 0; zero means done never came.
    task automatic run_cmd(input cmd_t op, input logic [3:0] a, input logic [3:0] b);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        op0   = stk_op;
        off0  = stk_offset;
        drop0 = stk_drop_tos;
        lat   = 0;
        e     = 3'h7;
        for (int k = 0; k < 30; k++) begin
            if (done) begin
                lat = k + 1;
                e   = err;
                break;
            end
            @(negedge clk);
        end
    endtask
    initial begin
        repeat (2) @(negedge clk);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_level", frame_level, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_op", stk_op, STK_NONE);
        chk("rst_limit", stk_upper_limit, 0);
        reset = 1'b0;
        stk_push(8'd5);
        stk_push(8'd7);
        run_cmd(CMD_CALL, 4'd2, 4'd1);
        chk("call_op", op0, STK_INDEX_RESET);
        chk("call_off", off0, 3);
        chk("call_lat", lat, 3);
        chk("call_err", e, ERR_NONE);
        chk("call_base", stk_lower_limit, 0);
        chk("call_limit", stk_upper_limit, 3);
        chk("call_uflim", stk_underflow_limit, 3);
        chk("call_level", frame_level, 1);
        chk("call_idx", s_idx, 3);
        run_cmd(CMD_LOCAL_GET, 4'd1, 4'd0);
        chk("get_op", op0, STK_UNDERFLOW_GET);
        chk("get_lat", lat, 5);
        chk("get_err", e, ERR_NONE);
        chk("get_idx", s_idx, 4);
        chk("get_tos", stk_out, 8'd7);
        run_cmd(CMD_LOCAL_GET, 4'd3, 4'd0);
        chk("getbad_err", e, ERR_BAD_LOCAL);
        chk("getbad_lat", lat, 3);
        chk("getbad_idx", s_idx, 4);
        stk_push(8'd9);
        run_cmd(CMD_LOCAL_SET, 4'd2, 4'd0);
        chk("set_op", op0, STK_UNDERFLOW_SET);
        chk("set_drop", drop0, 1);
        chk("set_err", e, ERR_NONE);
        chk("set_slot", s_mem[2], 8'd9);
        chk("set_idx", s_idx, 4);
        run_cmd(CMD_LOCAL_TEE, 4'd0, 4'd0);
        chk("tee_drop", drop0, 0);
        chk("tee_err", e, ERR_NONE);
        chk("tee_slot", s_mem[0], 8'd7);
        chk("tee_idx", s_idx, 4);
        stk_push(8'h2A);
        run_cmd(CMD_RETURN, 4'd1, 4'd0);
        chk("ret_op", op0, STK_INDEX_RESET_AND_PUSH);
        chk("ret_off", off0, 0);
        chk("ret_lat", lat, 3);
        chk("ret_err", e, ERR_NONE);
        chk("ret_idx", s_idx, 1);
        chk("ret_slot", s_mem[0], 8'h2A);
        chk("ret_level", frame_level, 0);
        chk("ret_limit", stk_upper_limit, 0);
        chk("ret_base", stk_lower_limit, 0);
        run_cmd(CMD_RETURN, 4'd0, 4'd0);
        chk("noframe_err", e, ERR_NO_FRAME);
        chk("noframe_lat", lat, 2);
        chk("noframe_op", op0, STK_NONE);
        for (int i = 0; i < 8; i++) begin
            run_cmd(CMD_CALL, 4'd0, 4'd0);
            chk("nest_err", e, ERR_NONE);
        end
        chk("nest_level", frame_level, 8);
        run_cmd(CMD_CALL, 4'd0, 4'd0);
        chk("ovf_err", e, ERR_FRAME_OVF);
        chk("ovf_op", op0, STK_NONE);
        chk("ovf_level", frame_level, 8);
        run_cmd(CMD_RETURN, 4'd0, 4'd0);
        chk("ret0_op", op0, STK_INDEX_RESET);
        chk("ret0_err", e, ERR_NONE);
        chk("ret0_level", frame_level, 7);
        run_cmd(CMD_CALL, 4'd1, 4'd0);
        chk("args_err", e, ERR_ARGS);
        run_cmd(CMD_CALL, 4'd0, 4'd8);
        chk("stkovf_err", e, ERR_STACK_OVF);
        chk("stkovf_level", frame_level, 7);
        run_cmd(CMD_CALL, 4'd0, 4'd7);
        chk("fill_err", e, ERR_NONE);
        chk("fill_off", off0, 8);
        chk("fill_limit", stk_upper_limit, 8);
        chk("fill_base", stk_lower_limit, 1);
        run_cmd(CMD_RETURN, 4'd1, 4'd0);
        chk("retuf_err", e, ERR_UNDERFLOW);
        chk("retuf_op", op0, STK_NONE);
        run_cmd(CMD_LOCAL_GET, 4'd0, 4'd0);
        chk("getovf_err", e, ERR_STACK_OVF);
        chk("getovf_lat", lat, 5);
        run_cmd(CMD_RETURN, 4'd0, 4'd0);
        chk("ret1_level", frame_level, 7);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = CMD_CALL;
        cmd_a     = 4'd0;
        cmd_b     = 4'd0;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_ready", cmd_ready, 1);
        chk("abort_level", frame_level, 0);
        chk("abort_done", done, 0);
        reset = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/frame_sequencer.md
Name: frame_sequencer

Overview:
- Call-frame controller in front of the operand stack (SuperStack) of the WASM CPU.
- Accepts CALL, RETURN, LOCAL_GET, LOCAL_SET and LOCAL_TEE commands from the decoder and sequences them into stack ops.
- Keeps an internal frame-record stack of {base, limit} pairs and drives the stack's underflow_limit, upper_limit and lower_limit.
- One command in flight at a time; valid/ready command handshake and a single-cycle done/err response.

Parameters:
- WIDTH, 8, operand stack data width in bits; must match the stack instance.
- DEPTH, 3, stack depth exponent; index and limit width is DEPTH+1.
- FRAMES, 8, frame-record capacity; a power of two, at least 2.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  3  frame_pkg::cmd_t: CALL, RETURN, LOCAL_GET, LOCAL_SET, LOCAL_TEE.
- cmd_a  in  DEPTH+1  CALL: nargs. Local ops: local index. RETURN: nresults (0 or 1).
- cmd_b  in  DEPTH+1  CALL: nlocals (non-argument locals). Ignored by other ops.
- done  out  1  one-cycle completion pulse.
- err  out  3  frame_pkg::err_t; valid with done, 0 otherwise.
- frame_level  out  $clog2(FRAMES)+1  number of live frame records.
- stk_op  out  3  stack op; NONE whenever the controller is not issuing an op.
- stk_data  out  WIDTH  data to the stack.
- stk_offset  out  DEPTH+1  offset to the stack.
- stk_underflow_limit  out  DEPTH+1  current frame limit.
- stk_upper_limit  out  DEPTH+1  current frame limit.
- stk_lower_limit  out  DEPTH+1  current frame base.
- stk_drop_tos  out  1  drop ToS on UNDERFLOW_SET.
- stk_index  in  DEPTH+1  stack index.
- stk_out  in  WIDTH  stack top of stack (ToS).
- stk_getter  in  WIDTH  stack getter result.
- stk_error  in  2  stack error; registered, so valid one cycle after the op.

Behaviour:
- Reset: state IDLE, base=0, limit=0, frame_level=0, done=0, err=0, stk_op=NONE. Frame-record storage contents are not reset.
- Mid-command reset aborts the command; no done pulse.
- States: IDLE, EXEC, CHECK, PUSH, CHECK2.
- Accept: cmd_valid&&cmd_ready in IDLE latches the command and moves to EXEC. cmd_ready is low in every other state.
- Prechecks in EXEC: a failed precheck issues no stack op, pulses done with the error next cycle, then returns to IDLE.
- CALL:
  - Precheck: frame_level==FRAMES → ERR_FRAME_OVF. nargs > stk_index-limit → ERR_ARGS. stk_index+nlocals > MAX_STACK → ERR_STACK_OVF.
  - EXEC: push {base,limit} to frame records; issue INDEX_RESET with offset=stk_index+nlocals.
  - Same cycle: base ← stk_index-nargs, limit ← stk_index+nlocals.
  - CHECK: done pulse. Total latency 3 cycles from accept.
- RETURN:
  - Precheck: frame_level==0 → ERR_NO_FRAME. nresults==1 and stk_index==limit → ERR_UNDERFLOW.
  - EXEC with nresults=1: INDEX_RESET_AND_PUSH, offset=base, data=stk_out.
  - EXEC with nresults=0: INDEX_RESET, offset=base.
  - Same cycle: pop the record and restore base/limit.
  - CHECK: done; stk_error≠NONE maps to ERR_STACK.
- LOCAL_GET:
  - EXEC: UNDERFLOW_GET, offset=idx.
  - CHECK: stk_error=BAD_OFFSET → done with ERR_BAD_LOCAL; otherwise go to PUSH.
  - PUSH: PUSH with data=stk_getter.
  - CHECK2: done; OVERFLOW maps to ERR_STACK_OVF. Latency 5 cycles.
- LOCAL_SET / LOCAL_TEE:
  - EXEC: UNDERFLOW_SET, data=stk_out, offset=idx; stk_drop_tos=1 for SET, 0 for TEE.
  - CHECK: done; BAD_OFFSET → ERR_BAD_LOCAL, UNDERFLOW → ERR_UNDERFLOW.
- Limit outputs: stk_lower_limit=base; stk_upper_limit and stk_underflow_limit = limit, driven continuously from registers.
- Arithmetic: unsigned, DEPTH+1 bits. Comparisons use one extra bit so sums never wrap.

Optional Feature:
- Macro FRAME_SEQUENCER_HWM_EN.
- Defined: adds output hwm [DEPTH:0], the maximum stk_index observed since reset (updated every cycle), and output frame_hwm, the maximum frame_level.
- Undefined: neither port exists; no logic is generated.

Decomposition:
- frame_pkg holds cmd_t, err_t (NONE, FRAME_OVF, NO_FRAME, ARGS, STACK_OVF, UNDERFLOW, BAD_LOCAL, STACK) and state_t.
- Stack op codes come from SuperStack.svh.
- Sub-module frame_record_lifo: FRAMES×2(DEPTH+1) LIFO with push/pop/full/empty/level, async-reset pointer. Instantiated once.

Test Plan:
- Push 5, 7 to the stack; CALL nargs=2 nlocals=1 → INDEX_RESET offset=3; base=0, limit=3, frame_level=1; done with err 0.
- LOCAL_GET idx=1 after that call → stack index 4, ToS=7, done 5 cycles after accept. LOCAL_GET idx=3 → err BAD_LOCAL, index unchanged.
- LOCAL_SET idx=2 with ToS=9 → slot 2=9, index decrements. LOCAL_TEE → slot written, index unchanged.
- RETURN nresults=1 with ToS=0x2A and base=0 → index=1, stack[0]=0x2A, frame_level=0, previous limits restored.
- RETURN at frame_level=0 → err NO_FRAME, stk_op stays NONE. FRAMES+1 nested CALLs → final call returns FRAME_OVF.
- Assert reset in EXEC of a CALL → cmd_ready=1, frame_level=0, done=0 the next cycle.
